// File: rtl/alu_md.sv
// EX-stage ALU for the multicycle MIPS core: single-cycle integer ops plus an
// iterative multiply/divide unit that owns the architectural HI/LO registers.
module alu_md #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUOp,
    input  logic [SHW-1:0]   shamt,
    input  logic             start,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned DW = 2 * WIDTH;

    localparam logic [4:0] OP_ADD   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_AND   = 5'h03;
    localparam logic [4:0] OP_OR    = 5'h04;
    localparam logic [4:0] OP_SLT   = 5'h05;
    localparam logic [4:0] OP_SLTU  = 5'h06;
    localparam logic [4:0] OP_NOR   = 5'h07;
    localparam logic [4:0] OP_SLL   = 5'h08;
    localparam logic [4:0] OP_SRL   = 5'h09;
    localparam logic [4:0] OP_LUI   = 5'h0A;
    localparam logic [4:0] OP_XOR   = 5'h0B;
    localparam logic [4:0] OP_SRA   = 5'h0C;
    localparam logic [4:0] OP_SLLV  = 5'h0D;
    localparam logic [4:0] OP_SRLV  = 5'h0E;
    localparam logic [4:0] OP_SRAV  = 5'h0F;
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MTHI  = 5'h14;
    localparam logic [4:0] OP_MTLO  = 5'h15;
    localparam logic [4:0] OP_MFHI  = 5'h16;
    localparam logic [4:0] OP_MFLO  = 5'h17;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    work_q, work_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             md_op, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nx, q_fix, r_fix;
    logic [DW-1:0]    step, prod_fix;

    // Launch decode: signed variants have ALUOp[0]=0, divides have ALUOp[1]=1
    always_comb begin
        md_op     = ALUOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        is_signed = ~ALUOp[0];
        a_neg     = is_signed & A[WIDTH-1];
        b_neg     = is_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
    end

    // One shift-add or restoring-divide iteration on magnitudes, plus sign fix-up
    always_comb begin
        mul_sum  = {1'b0, work_q[DW-1:WIDTH]} + (work_q[0] ? {1'b0, opd_q} : '0);
        rem_sh   = work_q[DW-1:WIDTH-1];
        div_ge   = rem_sh >= {1'b0, opd_q};
        rem_nx   = div_ge ? WIDTH'(rem_sh - {1'b0, opd_q}) : rem_sh[WIDTH-1:0];
        step     = div_q ? {rem_nx, work_q[WIDTH-2:0], div_ge}
                         : {mul_sum, work_q[WIDTH-1:1]};
        prod_fix = neg_q ? -step : step;
        q_fix    = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        r_fix    = rneg_q ? -step[DW-1:WIDTH] : step[DW-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opd_d   = opd_q;
        a_d     = a_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start && md_op) begin
                    state_d = S_RUN;
                    cnt_d   = CW'(WIDTH);
                    work_d  = {{WIDTH{1'b0}}, a_mag};
                    opd_d   = b_mag;
                    a_d     = A;
                    div_d   = ALUOp[1];
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end else if (start && ALUOp == OP_MTHI) begin
                    hi_d = A;
                end else if (start && ALUOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                work_d = step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIN;
                    if (!div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (opd_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = r_fix;
                        lo_d = q_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            opd_q   <= '0;
            a_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opd_q   <= opd_d;
            a_q     <= a_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Single-cycle result mux; HI/LO only change at the final iteration edge
    always_comb begin
        C = A;
        case (ALUOp)
            OP_ADD:  C = A + B;
            OP_SUB:  C = A - B;
            OP_AND:  C = A & B;
            OP_OR:   C = A | B;
            OP_SLT:  C = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: C = WIDTH'(A < B);
            OP_NOR:  C = ~(A | B);
            OP_SLL:  C = B << shamt;
            OP_SRL:  C = B >> shamt;
            OP_LUI:  C = B << 16;
            OP_XOR:  C = A ^ B;
            OP_SRA:  C = $signed(B) >>> shamt;
            OP_SLLV: C = B << A[SHW-1:0];
            OP_SRLV: C = B >> A[SHW-1:0];
            OP_SRAV: C = $signed(B) >>> A[SHW-1:0];
            OP_MFHI: C = hi_q;
            OP_MFLO: C = lo_q;
            default: C = A;
        endcase
    end

    assign Zero = (C == '0);
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_FIN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: stimulus pushes model results, a negedge monitor
// pops and compares them whenever C is strobed or done pulses.
module tb_alu_md;
    localparam int unsigned W = 32;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_ADD   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_SRA   = 5'h0C;
    localparam logic [4:0] OP_SRLV  = 5'h0E;
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MTHI  = 5'h14;
    localparam logic [4:0] OP_MTLO  = 5'h15;
    localparam logic [4:0] OP_MFHI  = 5'h16;
    localparam logic [4:0] OP_MFLO  = 5'h17;

    logic         clk;
    logic         rst;
    logic [W-1:0] A, B, C, hi, lo;
    logic [4:0]   ALUOp, shamt;
    logic         start, Zero, busy, done;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .ALUOp(ALUOp), .shamt(shamt),
        .start(start), .C(C), .Zero(Zero), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] md_q[$];
    logic [31:0] comb_q[$];
    logic        comb_vld = 1'b0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [63:0] last_exp = '0;
    int          run_len = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Architectural result of an MD op as {hi, lo}
    function automatic logic [63:0] md_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            OP_MULT: begin
                q = sa * sb;
                return 64'(q);
            end
            OP_MULTU: begin
                p = ua * ub;
                return p;
            end
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                p = ua / ub;
                ua = ua % ub;
                return {ua[31:0], p[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] comb_model(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        longint t;
        case (op)
            5'h01: return a + b;
            5'h02: return a - b;
            5'h03: return a & b;
            5'h04: return a | b;
            5'h05: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h06: return (a < b) ? 32'd1 : 32'd0;
            5'h07: return ~(a | b);
            5'h08: return b << sh;
            5'h09: return b >> sh;
            5'h0A: return {b[15:0], 16'h0};
            5'h0B: return a ^ b;
            5'h0C: begin t = longint'($signed(b)); t = t >>> sh; return t[31:0]; end
            5'h0D: return b << a[4:0];
            5'h0E: return b >> a[4:0];
            5'h0F: begin t = longint'($signed(b)); t = t >>> a[4:0]; return t[31:0]; end
            5'h16: return model_hi;
            5'h17: return model_lo;
            default: return a;
        endcase
    endfunction

    task automatic comb_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, input logic [31:0] exp);
        ALUOp = op; A = a; B = b; shamt = sh;
        comb_q.push_back(exp);
        comb_vld = 1'b1;
        @(posedge clk); #1;
        comb_vld = 1'b0;
    endtask

    task automatic comb_check(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh);
        comb_exp(op, a, b, sh, comb_model(op, a, b, sh));
    endtask

    task automatic md_launch_exp(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] exp);
        ALUOp = op; A = a; B = b; start = 1'b1;
        last_exp = exp;
        md_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        ALUOp = OP_NOP;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic md_launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        md_launch_exp(op, a, b, md_model(op, a, b));
    endtask

    // Returns at the negedge of the done cycle
    task automatic wait_done_neg();
        bit seen = 1'b0;
        for (int i = 0; i < int'(W) + 8; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", 64'(seen), 64'd1);
        {model_hi, model_lo} = last_exp;
    endtask

    task automatic wait_done();
        wait_done_neg();
        @(posedge clk); #1;
    endtask

    task automatic md_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        md_launch(op, a, b);
        wait_done();
    endtask

    task automatic mt_op(input logic [4:0] op, input logic [31:0] a);
        ALUOp = op; A = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (op == OP_MTHI) model_hi = a;
        else model_lo = a;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result
    initial begin
        logic [31:0] e;
        logic [63:0] e64;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len = 0;
            end else begin
                if (busy) run_len++;
                if (comb_vld) begin
                    if (comb_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL comb_q: actual empty required entry");
                    end else begin
                        e = comb_q.pop_front();
                        chk("C", 64'(C), 64'(e));
                        chk("Zero", 64'(Zero), 64'(e == 32'h0));
                    end
                end
                if (done) begin
                    if (md_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_done: actual done=1 required done=0");
                    end else begin
                        e64 = md_q.pop_front();
                        chk("hilo", {hi, lo}, e64);
                        chk("busy_len", 64'(run_len), 64'(W));
                    end
                    run_len = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [63:0] dummy;
        int          late_done;

        rst = 1'b1; start = 1'b0; A = '0; B = '0; ALUOp = OP_NOP; shamt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);

        comb_exp(OP_ADD, 32'd7, 32'hFFFF_FFFD, 5'd0, 32'd4);
        comb_exp(OP_SUB, 32'd5, 32'd5, 5'd0, 32'd0);
        comb_exp(OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
        comb_exp(OP_SRLV, 32'h24, 32'hF0, 5'd0, 32'hF);

        // Combinational opcode with start must not launch anything
        ALUOp = OP_ADD; A = 32'd1; B = 32'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("comb_start_busy", 64'(busy), 64'd0);
        chk("comb_start_hilo", {hi, lo}, 64'd0);

        md_launch_exp(OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB); wait_done();
        md_launch_exp(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE); wait_done();
        md_launch_exp(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD); wait_done();
        md_launch_exp(OP_DIVU, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF); wait_done();
        md_launch_exp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000); wait_done();
        md_launch_exp(OP_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF); wait_done();

        mt_op(OP_MTLO, 32'h1234);
        comb_exp(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'h1234);

        // MTHI mid-MULT is ignored; MFHI during busy still shows the old hi
        md_launch(OP_MULT, 32'h0001_2345, 32'hFFF6_789A);
        repeat (4) begin @(posedge clk); #1; end
        comb_check(OP_MFHI, 32'd0, 32'd0, 5'd0);
        ALUOp = OP_MTHI; A = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        comb_check(OP_MFHI, 32'd0, 32'd0, 5'd0);

        // Second start during busy is ignored
        md_launch(OP_DIVU, 32'd1000, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        ALUOp = OP_MULT; A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();

        // Start in the FIN cycle is accepted
        md_launch(OP_MULTU, 32'hABCD_0123, 32'h1111_2222);
        wait_done_neg();
        ALUOp = OP_DIV; A = 32'h8765_4321; B = 32'd13; start = 1'b1;
        last_exp = md_model(OP_DIV, 32'h8765_4321, 32'd13);
        md_q.push_back(last_exp);
        @(posedge clk); #1 start = 1'b0;
        chk("fin_start_busy", 64'(busy), 64'd1);
        wait_done();

        // Reset in cycle 10 of a DIV aborts it
        md_launch(OP_DIV, 32'hFFFF_0000, 32'd77);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        dummy = md_q.pop_back();
        @(posedge clk); #1 rst = 1'b0;
        model_hi = '0; model_lo = '0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        late_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("abort_no_done", 64'(late_done), 64'd0);
        @(posedge clk); #1;
        md_op(OP_MULTU, 32'h0000_FFFF, 32'h0001_0001);

        repeat (120) comb_check(5'($urandom_range(0, 31)), $urandom, $urandom,
                                5'($urandom_range(0, 31)));

        repeat (24) begin
            op = 5'(OP_MULT + 5'($urandom_range(0, 3)));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1
                                            : 32'($urandom);
            md_op(op, a, b);
            comb_check(OP_MFHI, $urandom, $urandom, 5'd0);
            comb_check(OP_MFLO, $urandom, $urandom, 5'd0);
            if ($urandom_range(0, 3) == 0) begin
                mt_op(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom);
                comb_check(OP_MFHI, $urandom, $urandom, 5'd0);
                comb_check(OP_MFLO, $urandom, $urandom, 5'd0);
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("md_q_drained", 64'(md_q.size()), 64'd0);
        chk("comb_q_drained", 64'(comb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
